axilite_slave_regbank: RTL and testbench
========================================

// Module: axilite_slave_regbank
// PURPOSE
//   AXI4-Lite slave register bank; terminates write/read transactions issued by the AXI4-Lite master.
//   Register 0 is a read-only status word; registers 1..NUM_REGS-1 are read/write control words.
//   The control words drive game control (speed, direction, enable); the status word reports game state.
//   Write and read channels are independent; each handles one outstanding transaction.
// PARAMETERS
//   AXI_DATA_WIDTH  32           data width; only 32 supported
//   AXI_ADDR_WIDTH  32           address width
//   NUM_REGS        8            number of 32-bit words, 2..64; index 0 is read-only
//   BASE_ADDR       32'h0000_0000  byte address of register 0
// PORTS
//   axi_clk        in   1                    single clock for all logic
//   reset          in   1                    asynchronous, active-low reset
//   s_axi_awaddr   in   AXI_ADDR_WIDTH       write address
//   s_axi_awprot   in   3                    ignored
//   s_axi_awvalid  in   1                    write address valid
//   s_axi_awready  out  1                    write address ready
//   s_axi_wdata    in   AXI_DATA_WIDTH       write data
//   s_axi_wstrb    in   AXI_DATA_WIDTH/8     byte-lane strobes
//   s_axi_wvalid   in   1                    write data valid
//   s_axi_wready   out  1                    write data ready
//   s_axi_bresp    out  2                    write response
//   s_axi_bvalid   out  1                    write response valid
//   s_axi_bready   in   1                    write response ready
//   s_axi_araddr   in   AXI_ADDR_WIDTH       read address
//   s_axi_arprot   in   3                    ignored
//   s_axi_arvalid  in   1                    read address valid
//   s_axi_arready  out  1                    read address ready
//   s_axi_rdata    out  AXI_DATA_WIDTH       read data
//   s_axi_rresp    out  2                    read response
//   s_axi_rvalid   out  1                    read data valid
//   s_axi_rready   in   1                    read data ready
//   status_in      in   32                   value returned for register 0
//   regs_out       out  NUM_REGS*32          flattened words; word i at [32*i+31:32*i]; word 0 = 0
//   reg_wr_pulse   out  NUM_REGS             1-cycle strobe per register on committed write
// BEHAVIOUR
//   Reset (reset=0, async): all ready/valid low; bresp, rresp and rdata 0; all registers 0; pulses 0.
//   Decode: off = addr - BASE_ADDR; idx = off[.. :2]; off[1:0] ignored.
//     In range when off < NUM_REGS*4; else the access gets SLVERR (2'b10).
//   Write FSM states: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
//     awready=1 in W_IDLE/W_HAVE_W; wready=1 in W_IDLE/W_HAVE_AW.
//     AW and W may arrive in either order or in the same cycle; the first one is latched.
//     When both are held: commit the write on that edge and enter W_RESP.
//     bvalid rises the cycle after the second handshake (latency 1).
//     bvalid stays high, with bresp stable, until bready; then return to W_IDLE.
//     No new AW or W is accepted while in W_RESP.
//     Commit: byte lane k is updated only if wstrb[k]=1; reg_wr_pulse[idx] goes high for exactly that cycle.
//     Commit to idx 0: no register change, no pulse, bresp OKAY.
//     Out-of-range write: no change, no pulse, bresp SLVERR.
//   Read FSM states: R_IDLE, R_RESP.
//     arready=1 only in R_IDLE.
//     On an AR handshake, rdata/rresp are registered and rvalid rises the next cycle (latency 1).
//     rdata, rresp and rvalid are held until rready; then return to R_IDLE. No back-to-back read while rvalid=1.
//     idx 0 returns status_in sampled at the AR handshake. Out of range: rdata=0, rresp SLVERR.
//   Simultaneous read and write commit on the same index in the same edge: read returns the pre-write value.
//   Reset asserted mid-transaction: both FSMs abort to idle immediately; pending responses are dropped.
// STRUCTURE
//   Shared package axilite_pkg:
//     RESP_OKAY=2'b00, RESP_SLVERR=2'b10, ADDR_LSB=2
//     write/read state encodings
//     function strb_merge(old, new, strb)
//   Package is also used by the AXI4-Lite master channels.
//   No sub-module: one file, two FSMs, one register array.
// TESTING
//   1. Write 0x4 = 0xDEADBEEF (strb 0xF), AW and W in the same cycle.
//      -> bvalid after 1 cycle, bresp 00; reg_wr_pulse[1] high 1 cycle; read 0x4 returns 0xDEADBEEF, OKAY.
//   2. W 3 cycles before AW, strb 0x5, data 0x11223344 to 0x8 holding 0xAAAAAAAA.
//      -> awready stays high; reg 2 = 0xAA22AA44.
//   3. bready held low 5 cycles.
//      -> bvalid and bresp stable; awready=wready=0 throughout; a new AW is accepted 1 cycle after bready.
//   4. Read 0x0 with status_in=0x0000_00A5; then write 0x0 = 0xFFFFFFFF.
//      -> rdata 0xA5 OKAY; write gives bresp OKAY, no pulse, read 0x0 still 0xA5.
//   5. Access 0x20 with NUM_REGS=8.
//      -> write bresp 2'b10, no register changes; read rdata 0, rresp 2'b10.
//   6. reset driven low while in W_HAVE_AW and while rvalid=1.
//      -> all outputs 0 asynchronously; after release a fresh write completes normally.

Source files
------------

// File: rtl/axilite_pkg.sv
// Shared AXI4-Lite definitions: response codes, address alignment and the
// channel state encodings used by both the slave register bank and the master.
package axilite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int         ADDR_LSB    = 2;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } r_state_e;

    function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        for (int k = 0; k < 4; k++) begin
            merged[8*k +: 8] = strb[k] ? new_val[8*k +: 8] : old_val[8*k +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/axilite_slave_regbank.sv
// AXI4-Lite slave register bank: word 0 is a read-only status view, words
// 1..NUM_REGS-1 are byte-writable control registers with per-word write strobes.
module axilite_slave_regbank
    import axilite_pkg::*;
#(
    parameter int                        AXI_DATA_WIDTH = 32,
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter int                        NUM_REGS       = 8,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
    input  logic                          axi_clk,
    input  logic                          reset,
    input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic [2:0]                    s_axi_awprot,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic [2:0]                    s_axi_arprot,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [AXI_DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    input  logic [31:0]                   status_in,
    output logic [NUM_REGS*32-1:0]        regs_out,
    output logic [NUM_REGS-1:0]           reg_wr_pulse
);

    localparam int                        IDX_W = $clog2(NUM_REGS);
    localparam logic [AXI_ADDR_WIDTH-1:0] SPAN  = AXI_ADDR_WIDTH'(NUM_REGS * 4);

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;

    logic                        awready_q, wready_q, bvalid_q;
    logic                        arready_q, rvalid_q;
    logic [1:0]                  bresp_q, rresp_q;
    logic [31:0]                 rdata_q;
    logic [AXI_ADDR_WIDTH-1:0]   awaddr_q;
    logic [31:0]                 wdata_q;
    logic [3:0]                  wstrb_q;
    logic [31:0]                 regs_q [1:NUM_REGS-1];
    logic [NUM_REGS-1:0]         pulse_q;

    logic                        aw_hs, w_hs, ar_hs;
    logic                        commit, latch_aw, latch_w;
    logic [AXI_ADDR_WIDTH-1:0]   c_addr, w_off, r_off;
    logic [31:0]                 c_data;
    logic [3:0]                  c_strb;
    logic [IDX_W-1:0]            w_idx, r_idx;
    logic                        w_in_range, r_in_range;
    logic [31:0]                 rd_word;
    logic                        unused_ok;

    assign unused_ok = ^{s_axi_awprot, s_axi_arprot};

    // Handshakes use the registered readies so reset forces them low.
    assign aw_hs = s_axi_awvalid & awready_q;
    assign w_hs  = s_axi_wvalid  & wready_q;
    assign ar_hs = s_axi_arvalid & arready_q;

    always_comb begin
        w_state_d = w_state_q;
        commit    = 1'b0;
        latch_aw  = 1'b0;
        latch_w   = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit    = 1'b1;
                    w_state_d = W_RESP;
                end else if (aw_hs) begin
                    latch_aw  = 1'b1;
                    w_state_d = W_HAVE_AW;
                end else if (w_hs) begin
                    latch_w   = 1'b1;
                    w_state_d = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                if (w_hs) begin
                    commit    = 1'b1;
                    w_state_d = W_RESP;
                end
            end
            W_HAVE_W: begin
                if (aw_hs) begin
                    commit    = 1'b1;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Whichever half arrived first is taken from its holding register.
    assign c_addr     = (w_state_q == W_HAVE_AW) ? awaddr_q : s_axi_awaddr;
    assign c_data     = (w_state_q == W_HAVE_W)  ? wdata_q  : s_axi_wdata;
    assign c_strb     = (w_state_q == W_HAVE_W)  ? wstrb_q  : s_axi_wstrb;
    assign w_off      = c_addr - BASE_ADDR;
    assign w_in_range = (w_off < SPAN);
    assign w_idx      = w_off[ADDR_LSB +: IDX_W];

    always_ff @(posedge axi_clk or negedge reset) begin
        if (!reset) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= (w_state_d == W_IDLE) || (w_state_d == W_HAVE_W);
            wready_q  <= (w_state_d == W_IDLE) || (w_state_d == W_HAVE_AW);
            bvalid_q  <= (w_state_d == W_RESP);
            if (latch_aw) begin
                awaddr_q <= s_axi_awaddr;
            end
            if (latch_w) begin
                wdata_q <= s_axi_wdata;
                wstrb_q <= s_axi_wstrb;
            end
            if (commit) begin
                bresp_q <= w_in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // Word 0 never matches here, so writes to it are silently acknowledged.
    always_ff @(posedge axi_clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            pulse_q <= '0;
        end else begin
            pulse_q <= '0;
            for (int i = 1; i < NUM_REGS; i++) begin
                if (commit && w_in_range && (w_idx == IDX_W'(i))) begin
                    regs_q[i]  <= strb_merge(regs_q[i], c_data, c_strb);
                    pulse_q[i] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (ar_hs)        r_state_d = R_RESP;
            R_RESP:  if (s_axi_rready) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    assign r_off      = s_axi_araddr - BASE_ADDR;
    assign r_in_range = (r_off < SPAN);
    assign r_idx      = r_off[ADDR_LSB +: IDX_W];

    always_comb begin
        rd_word = '0;
        if (r_in_range) begin
            if (r_idx == '0) begin
                rd_word = status_in;
            end
            for (int i = 1; i < NUM_REGS; i++) begin
                if (r_idx == IDX_W'(i)) begin
                    rd_word = regs_q[i];
                end
            end
        end
    end

    always_ff @(posedge axi_clk or negedge reset) begin
        if (!reset) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= (r_state_d == R_IDLE);
            rvalid_q  <= (r_state_d == R_RESP);
            if (ar_hs) begin
                rdata_q <= rd_word;
                rresp_q <= r_in_range ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;
    assign reg_wr_pulse  = pulse_q;

    assign regs_out[31:0] = '0;
    for (genvar g = 1; g < NUM_REGS; g++) begin : g_regs_out
        assign regs_out[32*g +: 32] = regs_q[g];
    end

endmodule

// File: tb/tb_axilite_slave_regbank.sv
// Directed bench for axilite_slave_regbank: handshake ordering, strobes,
// back-pressure, read-only and out-of-range words, and asynchronous reset.
module tb_axilite_slave_regbank;

    localparam int NR = 8;

    logic              axi_clk = 1'b0;
    logic              reset;
    logic [31:0]       s_axi_awaddr;
    logic [2:0]        s_axi_awprot;
    logic              s_axi_awvalid;
    logic              s_axi_awready;
    logic [31:0]       s_axi_wdata;
    logic [3:0]        s_axi_wstrb;
    logic              s_axi_wvalid;
    logic              s_axi_wready;
    logic [1:0]        s_axi_bresp;
    logic              s_axi_bvalid;
    logic              s_axi_bready;
    logic [31:0]       s_axi_araddr;
    logic [2:0]        s_axi_arprot;
    logic              s_axi_arvalid;
    logic              s_axi_arready;
    logic [31:0]       s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rvalid;
    logic              s_axi_rready;
    logic [31:0]       status_in;
    logic [NR*32-1:0]  regs_out;
    logic [NR-1:0]     reg_wr_pulse;

    int tests  = 0;
    int failed = 0;
    logic [31:0] exp_regs [NR];
    logic [1:0]  resp;
    logic [31:0] rd;

    always #5 axi_clk = ~axi_clk;

    axilite_slave_regbank #(
        .AXI_DATA_WIDTH(32),
        .AXI_ADDR_WIDTH(32),
        .NUM_REGS(NR),
        .BASE_ADDR(32'h0000_0000)
    ) dut (
        .axi_clk(axi_clk),
        .reset(reset),
        .s_axi_awaddr(s_axi_awaddr),
        .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid),
        .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata),
        .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp),
        .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr),
        .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata),
        .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready),
        .status_in(status_in),
        .regs_out(regs_out),
        .reg_wr_pulse(reg_wr_pulse)
    );

    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NR*32-1:0] flat();
        logic [NR*32-1:0] f;
        for (int i = 0; i < NR; i++) f[32*i +: 32] = (i == 0) ? 32'h0 : exp_regs[i];
        return f;
    endfunction

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [1:0] r);
        logic aw_done, w_done, got, aw_r, w_r;
        aw_done = 1'b0; w_done = 1'b0; got = 1'b0; r = 2'b11;
        s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        for (int n = 0; n < 20 && !(aw_done && w_done); n++) begin
            aw_r = s_axi_awready; w_r = s_axi_wready;
            tick();
            if (aw_r) begin aw_done = 1'b1; s_axi_awvalid = 1'b0; end
            if (w_r)  begin w_done  = 1'b1; s_axi_wvalid  = 1'b0; end
        end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b1;
        for (int n = 0; n < 20 && !got; n++) begin
            if (s_axi_bvalid) begin got = 1'b1; r = s_axi_bresp; end
            tick();
        end
        s_axi_bready = 1'b0;
        check("wr_complete", {255'b0, got}, 256'd1);
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        logic ar_done, got, ar_r;
        ar_done = 1'b0; got = 1'b0; d = 32'hxxxx_xxxx; r = 2'b11;
        s_axi_araddr = a; s_axi_arvalid = 1'b1;
        for (int n = 0; n < 20 && !ar_done; n++) begin
            ar_r = s_axi_arready;
            tick();
            if (ar_r) ar_done = 1'b1;
        end
        s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b1;
        for (int n = 0; n < 20 && !got; n++) begin
            if (s_axi_rvalid) begin got = 1'b1; d = s_axi_rdata; r = s_axi_rresp; end
            tick();
        end
        s_axi_rready = 1'b0;
        check("rd_complete", {255'b0, got}, 256'd1);
    endtask

    initial begin
        for (int i = 0; i < NR; i++) exp_regs[i] = 32'h0;
        reset = 1'b0;
        s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
        s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        status_in = 32'h0;

        tick();
        check("rst_awready", s_axi_awready, 0);
        check("rst_bvalid", s_axi_bvalid, 0);
        check("rst_arready", s_axi_arready, 0);
        check("rst_rdata", s_axi_rdata, 0);
        check("rst_regs", regs_out, 0);
        reset = 1'b1;
        tick(); tick();

        // 1: AW and W together
        check("t1_awready", s_axi_awready, 1);
        check("t1_wready", s_axi_wready, 1);
        s_axi_awaddr = 32'h4; s_axi_wdata = 32'hDEADBEEF; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        exp_regs[1] = 32'hDEADBEEF;
        check("t1_bvalid", s_axi_bvalid, 1);
        check("t1_bresp", s_axi_bresp, 2'b00);
        check("t1_pulse", reg_wr_pulse, 8'b0000_0010);
        check("t1_regs", regs_out, flat());
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        check("t1_pulse_off", reg_wr_pulse, 0);
        check("t1_bvalid_off", s_axi_bvalid, 0);
        s_axi_araddr = 32'h4; s_axi_arvalid = 1'b1;
        tick();
        s_axi_arvalid = 1'b0;
        check("t1_rvalid", s_axi_rvalid, 1);
        check("t1_rdata", s_axi_rdata, 32'hDEADBEEF);
        check("t1_rresp", s_axi_rresp, 2'b00);
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
        check("t1_rvalid_off", s_axi_rvalid, 0);

        // 2: W three cycles ahead of AW, partial strobe
        do_write(32'h8, 32'hAAAAAAAA, 4'hF, resp);
        exp_regs[2] = 32'hAAAAAAAA;
        check("t2_pre_bresp", resp, 2'b00);
        s_axi_wdata = 32'h11223344; s_axi_wstrb = 4'h5; s_axi_wvalid = 1'b1;
        tick();
        s_axi_wvalid = 1'b0;
        check("t2_awready0", s_axi_awready, 1);
        check("t2_wready0", s_axi_wready, 0);
        tick();
        check("t2_awready1", s_axi_awready, 1);
        tick();
        check("t2_awready2", s_axi_awready, 1);
        s_axi_awaddr = 32'h8; s_axi_awvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        exp_regs[2] = 32'hAA22AA44;
        check("t2_bvalid", s_axi_bvalid, 1);
        check("t2_pulse", reg_wr_pulse, 8'b0000_0100);
        check("t2_regs", regs_out, flat());

        // 3: response back-pressure, new request waiting
        s_axi_awaddr = 32'hC; s_axi_wdata = 32'h55555555; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        for (int n = 0; n < 5; n++) begin
            check("t3_bvalid", s_axi_bvalid, 1);
            check("t3_bresp", s_axi_bresp, 2'b00);
            check("t3_awready", s_axi_awready, 0);
            check("t3_wready", s_axi_wready, 0);
            check("t3_regs_hold", regs_out, flat());
            tick();
        end
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        check("t3_bvalid_off", s_axi_bvalid, 0);
        check("t3_awready_back", s_axi_awready, 1);
        check("t3_regs_nochg", regs_out, flat());
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        exp_regs[3] = 32'h55555555;
        check("t3_new_bvalid", s_axi_bvalid, 1);
        check("t3_new_pulse", reg_wr_pulse, 8'b0000_1000);
        check("t3_new_regs", regs_out, flat());
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;

        // 4: status word, sampled at AR and write-protected
        status_in = 32'h0000_00A5;
        s_axi_araddr = 32'h0; s_axi_arvalid = 1'b1;
        tick();
        s_axi_arvalid = 1'b0;
        status_in = 32'h0000_005A;
        tick();
        check("t4_rdata", s_axi_rdata, 32'hA5);
        check("t4_rresp", s_axi_rresp, 2'b00);
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
        status_in = 32'h0000_00A5;
        s_axi_awaddr = 32'h0; s_axi_wdata = 32'hFFFFFFFF; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        check("t4_bvalid", s_axi_bvalid, 1);
        check("t4_bresp", s_axi_bresp, 2'b00);
        check("t4_no_pulse", reg_wr_pulse, 0);
        check("t4_regs", regs_out, flat());
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        do_read(32'h0, rd, resp);
        check("t4_reread", rd, 32'hA5);

        // 5: out of range and boundary words
        do_write(32'h20, 32'h12345678, 4'hF, resp);
        check("t5_bresp", resp, 2'b10);
        check("t5_regs", regs_out, flat());
        do_read(32'h20, rd, resp);
        check("t5_rdata", rd, 0);
        check("t5_rresp", resp, 2'b10);
        do_read(32'h1C, rd, resp);
        check("t5_last_rresp", resp, 2'b00);
        check("t5_last_rdata", rd, 0);
        do_read(32'h6, rd, resp);
        check("t5_unaligned", rd, 32'hDEADBEEF);

        // same-edge read and write of one word
        s_axi_awaddr = 32'h4; s_axi_wdata = 32'h0BADF00D; s_axi_wstrb = 4'hF;
        s_axi_araddr = 32'h4;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        exp_regs[1] = 32'h0BADF00D;
        check("rw_old_value", s_axi_rdata, 32'hDEADBEEF);
        check("rw_new_reg", regs_out, flat());
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        tick();
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;

        // 6: asynchronous reset mid-transaction
        s_axi_awaddr = 32'hC; s_axi_awvalid = 1'b1;
        s_axi_araddr = 32'h4; s_axi_arvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
        check("t6_have_aw", {s_axi_awready, s_axi_wready}, 2'b01);
        check("t6_rvalid", s_axi_rvalid, 1);
        #2 reset = 1'b0;
        #1;
        check("t6_awready", s_axi_awready, 0);
        check("t6_wready", s_axi_wready, 0);
        check("t6_rvalid0", s_axi_rvalid, 0);
        check("t6_rdata0", s_axi_rdata, 0);
        check("t6_arready0", s_axi_arready, 0);
        check("t6_regs0", regs_out, 0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < NR; i++) exp_regs[i] = 32'h0;
        tick(); tick();
        do_write(32'h10, 32'hCAFEF00D, 4'hF, resp);
        exp_regs[4] = 32'hCAFEF00D;
        check("t6_bresp", resp, 2'b00);
        check("t6_regs", regs_out, flat());
        do_read(32'h10, rd, resp);
        check("t6_rdata", rd, 32'hCAFEF00D);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
